hx8352_init_sequencer: RTL

- Walks an external init-table ROM and sequences the HX8352 panel bring-up: command writes, data writes and millisecond delays.
- Issues each write to the bus writer over a valid/ready handshake.
- Delays are handed to the millisecond delay unit via a step edge plus `delay_ms`, then the block waits on that unit's `done`.
- Sits between the top-level start/reset logic and the bus-writer and delay-timer datapath.

---
 rtl/hx8352_init_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hx8352_init_sequencer.sv
// Purpose: walks an init-table ROM and issues HX8352 command/data writes and ms delays.
// Latency: 3 cycles minimum per write entry (FETCH, DECODE, WR); 2 cycles per skipped zero delay.
// Backpressure: holds wr_valid/wr_dc/wr_data until wr_ready; waits on dly_done for delays.
// Optional: define HX8352_SEQ_ARM_TIMEOUT_EN to bound the wait for the delay unit to arm.
module hx8352_init_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int ARM_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              wr_dc,
    output logic [7:0]        wr_data,
    output logic              dly_step,
    output logic [7:0]        dly_ms,
    input  logic              dly_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WR,
        S_DLY_STEP,
        S_DLY_ARM,
        S_DLY_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_CMD   = 2'b00;
    localparam logic [1:0] OP_DATA  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;

    state_t            state, state_nxt;
    logic              start_q;
    logic              start_edge;
    logic [ADDR_W-1:0] addr_nxt;
    logic              dc_nxt;
    logic [7:0]        data_nxt;
    logic [7:0]        ms_nxt;
    logic              addr_last;
    state_t            adv_state;
    logic [ADDR_W-1:0] adv_addr;

`ifdef HX8352_SEQ_ARM_TIMEOUT_EN
    localparam logic [23:0] ARM_LIMIT = 24'(ARM_TIMEOUT - 1);
    logic [23:0] arm_cnt, arm_cnt_nxt;
`else
    // ARM_TIMEOUT has no effect when the arm wait is unbounded.
    logic unused_arm_timeout;
    assign unused_arm_timeout = ^ARM_TIMEOUT;
`endif

    assign start_edge = start & ~start_q;
    assign addr_last  = (rom_addr == {ADDR_W{1'b1}});

    // Moving past the last table slot is an overrun, never a wrap to 0.
    assign adv_state = addr_last ? S_ERR : S_FETCH;
    assign adv_addr  = addr_last ? rom_addr : rom_addr + 1'b1;

    // Outputs decoded straight from state so reset drops them in the same cycle.
    assign wr_valid = (state == S_WR);
    assign dly_step = (state == S_DLY_STEP);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign busy     = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            rom_addr <= '0;
            wr_dc    <= 1'b0;
            wr_data  <= 8'h00;
            dly_ms   <= 8'h00;
`ifdef HX8352_SEQ_ARM_TIMEOUT_EN
            arm_cnt  <= 24'd0;
`endif
        end else begin
            state    <= state_nxt;
            start_q  <= start;
            rom_addr <= addr_nxt;
            wr_dc    <= dc_nxt;
            wr_data  <= data_nxt;
            dly_ms   <= ms_nxt;
`ifdef HX8352_SEQ_ARM_TIMEOUT_EN
            arm_cnt  <= arm_cnt_nxt;
`endif
        end
    end

    // Next-state and datapath update for the table walk.
    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        dc_nxt    = wr_dc;
        data_nxt  = wr_data;
        ms_nxt    = dly_ms;
`ifdef HX8352_SEQ_ARM_TIMEOUT_EN
        arm_cnt_nxt = arm_cnt;
`endif
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_edge) begin
                    state_nxt = S_FETCH;
                    addr_nxt  = '0;
                end
            end
            S_FETCH: begin
                // rom_data follows rom_addr by one cycle.
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (rom_data[9:8])
                    OP_CMD, OP_DATA: begin
                        dc_nxt    = rom_data[8];
                        data_nxt  = rom_data[7:0];
                        state_nxt = S_WR;
                    end
                    OP_DELAY: begin
                        if (rom_data[7:0] == 8'h00) begin
                            state_nxt = adv_state;
                            addr_nxt  = adv_addr;
                        end else begin
                            ms_nxt    = rom_data[7:0];
                            state_nxt = S_DLY_STEP;
                        end
                    end
                    default: state_nxt = S_DONE;
                endcase
            end
            S_WR: begin
                if (wr_ready) begin
                    state_nxt = adv_state;
                    addr_nxt  = adv_addr;
                end
            end
            S_DLY_STEP: begin
                state_nxt = S_DLY_ARM;
`ifdef HX8352_SEQ_ARM_TIMEOUT_EN
                arm_cnt_nxt = 24'd0;
`endif
            end
            S_DLY_ARM: begin
                // A done level left over from the previous delay is not completion.
                if (!dly_done) begin
                    state_nxt = S_DLY_WAIT;
`ifdef HX8352_SEQ_ARM_TIMEOUT_EN
                end else if (arm_cnt == ARM_LIMIT) begin
                    state_nxt = S_ERR;
                end else begin
                    arm_cnt_nxt = arm_cnt + 24'd1;
`endif
                end
            end
            S_DLY_WAIT: begin
                if (dly_done) begin
                    state_nxt = adv_state;
                    addr_nxt  = adv_addr;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
